// File: rtl/cpu_fpu_issue.sv
`default_nettype none
// ============================================================================
// Module   : cpu_fpu_issue
// Purpose  : Issue-side controller for the FP functional units. Accepts one
//            FP op from execute and dispatches it over a request/ready
//            4-phase handshake to the add, mul or div unit. SUB reuses the
//            add unit with the op2 sign flipped. MIN/MAX/SGNJ/SGNJN are
//            resolved locally in one cycle. A watchdog aborts a hung unit.
// Ports    : i_clock, i_reset          clock, synchronous active-high reset
//            i_start, i_op, i_op1/2    op strobe, opcode, operands
//            o_busy, o_done, o_result  status, completion pulse, result
//            o_timeout                 qualifies o_done on a watchdog abort
//            o_add/mul/div_request     per-unit request (at most one high)
//            o_unit_op1/op2            operands shared by all units
//            i_add/mul/div_ready       per-unit ready
//            i_add/mul/div_result      per-unit result
// Revision : 1.0  initial release
// ============================================================================
module cpu_fpu_issue #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [2:0]  i_op,
   input  logic [31:0] i_op1,
   input  logic [31:0] i_op2,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_result,
   output logic        o_timeout,
   output logic        o_add_request,
   output logic        o_mul_request,
   output logic        o_div_request,
   output logic [31:0] o_unit_op1,
   output logic [31:0] o_unit_op2,
   input  logic        i_add_ready,
   input  logic        i_mul_ready,
   input  logic        i_div_ready,
   input  logic [31:0] i_add_result,
   input  logic [31:0] i_mul_result,
   input  logic [31:0] i_div_result
);

   localparam logic [2:0]  OP_ADD   = 3'd0;
   localparam logic [2:0]  OP_SUB   = 3'd1;
   localparam logic [2:0]  OP_MUL   = 3'd2;
   localparam logic [2:0]  OP_DIV   = 3'd3;
   localparam logic [2:0]  OP_MIN   = 3'd4;
   localparam logic [2:0]  OP_MAX   = 3'd5;
   localparam logic [2:0]  OP_SGNJ  = 3'd6;
   localparam logic [31:0] QNAN     = 32'h7fc00000;

   // Counter runs 0..TIMEOUT_CYCLES-1; the abort fires on the cycle the
   // count sits at its last value, i.e. the TIMEOUT_CYCLES-th wait cycle.
   localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic            WD_ON    = (TIMEOUT_CYCLES != 0);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      LOCAL      = 2'd1,
      WAIT_READY = 2'd2,
      WAIT_DROP  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [31:0]       op1_q, op1_d;
   logic [31:0]       op2_q, op2_d;
   logic [31:0]       uop2_q, uop2_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              timeout_q, timeout_d;
   logic [31:0]       result_q, result_d;
   logic              add_req_q, add_req_d;
   logic              mul_req_q, mul_req_d;
   logic              div_req_q, div_req_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              sel_ready;
   logic [31:0]       sel_result;
   logic [31:0]       local_result;

   function automatic logic is_nan(input logic [31:0] v);
      return (v[30:23] == 8'hff) && (v[22:0] != 23'd0);
   endfunction

   // Sign-magnitude ordering; a sign difference alone decides, so -0 < +0.
   function automatic logic less_than(input logic [31:0] a, input logic [31:0] b);
      if (a[31] != b[31])
         return a[31];
      else if (!a[31])
         return a[30:0] < b[30:0];
      else
         return a[30:0] > b[30:0];
   endfunction

   // Only ops 0-3 reach the unit states, so op[1:0] names the unit
   // (ADD and SUB share the add unit). Other units' readies are ignored.
   always_comb begin
      sel_ready  = 1'b0;
      sel_result = 32'd0;
      case (op_q[1:0])
         2'd0, 2'd1: begin sel_ready = i_add_ready; sel_result = i_add_result; end
         2'd2:       begin sel_ready = i_mul_ready; sel_result = i_mul_result; end
         default:    begin sel_ready = i_div_ready; sel_result = i_div_result; end
      endcase
   end

   always_comb begin
      logic nan1, nan2, op1_less;
      nan1         = is_nan(op1_q);
      nan2         = is_nan(op2_q);
      op1_less     = less_than(op1_q, op2_q);
      local_result = {~op2_q[31], op1_q[30:0]};
      case (op_q)
         OP_MIN, OP_MAX: begin
            if (nan1 && nan2)
               local_result = QNAN;
            else if (nan1)
               local_result = op2_q;
            else if (nan2)
               local_result = op1_q;
            else if (op_q == OP_MIN)
               local_result = op1_less ? op1_q : op2_q;
            else
               local_result = op1_less ? op2_q : op1_q;
         end
         OP_SGNJ: local_result = {op2_q[31], op1_q[30:0]};
         default: local_result = {~op2_q[31], op1_q[30:0]};
      endcase
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      op1_d     = op1_q;
      op2_d     = op2_q;
      uop2_d    = uop2_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      timeout_d = 1'b0;
      result_d  = result_q;
      add_req_d = add_req_q;
      mul_req_d = mul_req_q;
      div_req_d = div_req_q;
      cnt_d     = cnt_q;

      case (state_q)
         IDLE: begin
            if (i_start) begin
               op_d   = i_op;
               op1_d  = i_op1;
               op2_d  = i_op2;
               busy_d = 1'b1;
               cnt_d  = '0;
               if (!i_op[2]) begin
                  uop2_d    = (i_op == OP_SUB) ? {~i_op2[31], i_op2[30:0]} : i_op2;
                  add_req_d = (i_op == OP_ADD) || (i_op == OP_SUB);
                  mul_req_d = (i_op == OP_MUL);
                  div_req_d = (i_op == OP_DIV);
                  state_d   = WAIT_READY;
               end else begin
                  state_d   = LOCAL;
               end
            end
         end

         LOCAL: begin
            result_d = local_result;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = IDLE;
         end

         WAIT_READY: begin
            if (sel_ready) begin
               result_d  = sel_result;
               done_d    = 1'b1;
               add_req_d = 1'b0;
               mul_req_d = 1'b0;
               div_req_d = 1'b0;
               state_d   = WAIT_DROP;
            end else if (WD_ON && (cnt_q == CNT_LAST)) begin
               result_d  = QNAN;
               done_d    = 1'b1;
               timeout_d = 1'b1;
               add_req_d = 1'b0;
               mul_req_d = 1'b0;
               div_req_d = 1'b0;
               state_d   = WAIT_DROP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            // Hold off until the unit releases ready so a lingering ready
            // cannot complete the next op.
            if (!sel_ready) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q   <= IDLE;
         op_q      <= 3'd0;
         op1_q     <= 32'd0;
         op2_q     <= 32'd0;
         uop2_q    <= 32'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         result_q  <= 32'd0;
         add_req_q <= 1'b0;
         mul_req_q <= 1'b0;
         div_req_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         op1_q     <= op1_d;
         op2_q     <= op2_d;
         uop2_q    <= uop2_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
         result_q  <= result_d;
         add_req_q <= add_req_d;
         mul_req_q <= mul_req_d;
         div_req_q <= div_req_d;
         cnt_q     <= cnt_d;
      end
   end

   assign o_busy        = busy_q;
   assign o_done        = done_q;
   assign o_result      = result_q;
   assign o_timeout     = timeout_q;
   assign o_add_request = add_req_q;
   assign o_mul_request = mul_req_q;
   assign o_div_request = div_req_q;
   assign o_unit_op1    = op1_q;
   assign o_unit_op2    = uop2_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_fpu_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_fpu_issue
// Purpose  : Self-checking bench for cpu_fpu_issue. Expected completions are
//            queued at issue time and popped by a monitor on every o_done.
//            A second instance with an 8-cycle watchdog covers the abort.
// Revision : 1.0  initial release
// ============================================================================
module tb_cpu_fpu_issue;

   typedef struct packed {
      logic [31:0] res;
      logic        to;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op_in = 3'd0;
   logic [31:0] op1_in = 32'd0, op2_in = 32'd0;
   logic        busy, done, timeout;
   logic [31:0] result, unit_op1, unit_op2;
   logic        add_request, mul_request, div_request;
   logic [2:0]  unit_ready;
   logic [31:0] unit_res [3];
   int          unit_lat [3];
   int          unit_hold [3];
   int          unit_cnt [3];
   int          unit_hcnt [3];
   logic [2:0]  reqs;

   logic        wd_start = 1'b0;
   logic        wd_busy, wd_done, wd_timeout;
   logic [31:0] wd_result, wd_uop1, wd_uop2;
   logic        wd_add_req, wd_mul_req, wd_div_req;

   exp_t        exp_q[$];
   exp_t        wd_q[$];
   int          checks = 0;
   int          fails  = 0;

   always #5 clock = ~clock;

   cpu_fpu_issue #(.TIMEOUT_CYCLES(255)) dut (
      .i_clock(clock), .i_reset(reset), .i_start(start), .i_op(op_in),
      .i_op1(op1_in), .i_op2(op2_in), .o_busy(busy), .o_done(done),
      .o_result(result), .o_timeout(timeout), .o_add_request(add_request),
      .o_mul_request(mul_request), .o_div_request(div_request),
      .o_unit_op1(unit_op1), .o_unit_op2(unit_op2),
      .i_add_ready(unit_ready[0]), .i_mul_ready(unit_ready[1]), .i_div_ready(unit_ready[2]),
      .i_add_result(unit_res[0]), .i_mul_result(unit_res[1]), .i_div_result(unit_res[2])
   );

   cpu_fpu_issue #(.TIMEOUT_CYCLES(8)) dut_wd (
      .i_clock(clock), .i_reset(reset), .i_start(wd_start), .i_op(3'd3),
      .i_op1(32'h3f800000), .i_op2(32'h40000000), .o_busy(wd_busy), .o_done(wd_done),
      .o_result(wd_result), .o_timeout(wd_timeout), .o_add_request(wd_add_req),
      .o_mul_request(wd_mul_req), .o_div_request(wd_div_req),
      .o_unit_op1(wd_uop1), .o_unit_op2(wd_uop2),
      .i_add_ready(1'b0), .i_mul_ready(1'b0), .i_div_ready(1'b0),
      .i_add_result(32'd0), .i_mul_result(32'd0), .i_div_result(32'd0)
   );

   assign reqs = {div_request, mul_request, add_request};

   // Unit model: ready rises on the lat-th edge that sees request, and
   // falls hold+1 edges after request drops.
   always @(posedge clock) begin
      for (int u = 0; u < 3; u++) begin
         if (reset) begin
            unit_ready[u] <= 1'b0;
            unit_cnt[u]   <= 0;
            unit_hcnt[u]  <= 0;
         end else if (reqs[u] && !unit_ready[u]) begin
            if (unit_cnt[u] + 1 == unit_lat[u]) unit_ready[u] <= 1'b1;
            else                                unit_cnt[u]   <= unit_cnt[u] + 1;
         end else if (!reqs[u] && unit_ready[u]) begin
            if (unit_hcnt[u] >= unit_hold[u]) begin
               unit_ready[u] <= 1'b0;
               unit_cnt[u]   <= 0;
               unit_hcnt[u]  <= 0;
            end else begin
               unit_hcnt[u] <= unit_hcnt[u] + 1;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor for both instances.
   always @(negedge clock) begin
      exp_t e;
      if (done) begin
         if (exp_q.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("result", result, e.res);
            check("timeout_flag", {31'd0, timeout}, {31'd0, e.to});
         end
      end
      if (wd_done) begin
         if (wd_q.size() == 0) begin
            check("wd_spurious_done", 32'd1, 32'd0);
         end else begin
            e = wd_q.pop_front();
            check("wd_result", wd_result, e.res);
            check("wd_timeout_flag", {31'd0, wd_timeout}, {31'd0, e.to});
         end
      end
   end

   task automatic push(input logic [31:0] res, input logic to);
      exp_t e;
      e.res = res;
      e.to  = to;
      exp_q.push_back(e);
   endtask

   // Issues one op and returns the number of negedges up to o_done, the
   // OR of all requests seen meanwhile, and o_unit_op2 one cycle in.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int n, output logic [2:0] seen, output logic [31:0] uop2);
      @(negedge clock);
      start = 1'b1; op_in = op; op1_in = a; op2_in = b;
      n = 0; seen = 3'd0; uop2 = 32'd0;
      do begin
         @(negedge clock);
         start = 1'b0;
         n++;
         if (n == 1) uop2 = unit_op2;
         seen |= reqs;
      end while (!done && n < 400);
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while (busy && k < 100) begin
         @(negedge clock);
         k++;
      end
      check(name, {31'd0, busy}, 32'd0);
   endtask

   task automatic local_op(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
      int n; logic [2:0] seen; logic [31:0] u2;
      push(exp, 1'b0);
      run_op(op, a, b, n, seen, u2);
      check({name, "_latency"}, n, 32'd2);
      check({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      check({name, "_no_request"}, {29'd0, seen}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1, "bench hang");
   end

   initial begin
      int n; logic [2:0] seen; logic [31:0] u2; int k; logic any;
      for (int u = 0; u < 3; u++) begin
         unit_res[u] = 32'd0; unit_lat[u] = 1; unit_hold[u] = 0;
      end
      repeat (3) @(negedge clock);
      reset = 1'b0;

      // Reset state
      check("rst_busy",    {31'd0, busy}, 32'd0);
      check("rst_done",    {31'd0, done}, 32'd0);
      check("rst_timeout", {31'd0, timeout}, 32'd0);
      check("rst_result",  result, 32'd0);
      check("rst_reqs",    {29'd0, reqs}, 32'd0);
      check("rst_uop1",    unit_op1, 32'd0);
      check("rst_uop2",    unit_op2, 32'd0);

      // ADD 1.0 + 2.0, ready 12 cycles after request
      unit_lat[0] = 12; unit_res[0] = 32'h40400000;
      push(32'h40400000, 1'b0);
      run_op(3'd0, 32'h3f800000, 32'h40000000, n, seen, u2);
      check("add_latency", n, 32'd14);
      check("add_reqs_seen", {29'd0, seen}, 32'd1);
      check("add_req_low_at_done", {31'd0, add_request}, 32'd0);
      check("add_busy_at_done", {31'd0, busy}, 32'd1);
      check("add_uop2", u2, 32'h40000000);
      @(negedge clock);
      check("add_busy_ready_still_high", {31'd0, busy}, 32'd1);
      @(negedge clock);
      check("add_busy_after_drop", {31'd0, busy}, 32'd0);

      // SUB 3.0 - 1.0 through the add unit with op2 negated
      unit_lat[0] = 4; unit_res[0] = 32'h40000000;
      push(32'h40000000, 1'b0);
      run_op(3'd1, 32'h40400000, 32'h3f800000, n, seen, u2);
      check("sub_uop2", u2, 32'hbf800000);
      check("sub_reqs_seen", {29'd0, seen}, 32'd1);
      check("sub_latency", n, 32'd6);
      wait_idle("sub_idle");

      // MUL: NaN from the unit passes through unchanged
      unit_lat[1] = 3; unit_res[1] = 32'hffc00000;
      push(32'hffc00000, 1'b0);
      run_op(3'd2, 32'h7f800000, 32'h00000000, n, seen, u2);
      check("mul_reqs_seen", {29'd0, seen}, 32'd2);
      check("mul_latency", n, 32'd5);
      wait_idle("mul_idle");

      // DIV 1.0 / 2.0
      unit_lat[2] = 2; unit_res[2] = 32'h3f000000;
      push(32'h3f000000, 1'b0);
      run_op(3'd3, 32'h3f800000, 32'h40000000, n, seen, u2);
      check("div_reqs_seen", {29'd0, seen}, 32'd4);
      check("div_latency", n, 32'd4);
      wait_idle("div_idle");

      // Local ops
      local_op("min_nan",   3'd4, 32'h7fc00001, 32'hbf800000, 32'hbf800000);
      local_op("max_zero",  3'd5, 32'h80000000, 32'h00000000, 32'h00000000);
      local_op("min_zero",  3'd4, 32'h80000000, 32'h00000000, 32'h80000000);
      local_op("min_sign",  3'd4, 32'h40000000, 32'hc0000000, 32'hc0000000);
      local_op("max_neg",   3'd5, 32'hc0000000, 32'hbf800000, 32'hbf800000);
      local_op("max_2nan",  3'd5, 32'h7fc00001, 32'h7f800001, 32'h7fc00000);
      local_op("sgnj",      3'd6, 32'h3f800000, 32'hbf800000, 32'hbf800000);
      local_op("sgnjn",     3'd7, 32'h3f800000, 32'h3f800000, 32'hbf800000);

      // Ready held 5 extra cycles; starts in that window are dropped
      unit_lat[0] = 2; unit_hold[0] = 5; unit_res[0] = 32'h3f800000;
      push(32'h3f800000, 1'b0);
      run_op(3'd0, 32'h3f000000, 32'h3f000000, n, seen, u2);
      check("hold_latency", n, 32'd4);
      seen = 3'd0;
      for (int i = 0; i < 4; i++) begin
         start = 1'b1; op_in = 3'd2; op1_in = 32'h40000000; op2_in = 32'h40000000;
         @(negedge clock);
         seen |= reqs;
      end
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         seen |= reqs;
      end
      check("hold_stray_ignored", {29'd0, seen}, 32'd0);
      wait_idle("hold_idle");
      unit_hold[0] = 0; unit_lat[0] = 2; unit_res[0] = 32'h40800000;
      push(32'h40800000, 1'b0);
      run_op(3'd0, 32'h40000000, 32'h40000000, n, seen, u2);
      check("after_hold_latency", n, 32'd4);
      wait_idle("after_hold_idle");

      // Reset pulsed mid WAIT_READY
      unit_lat[0] = 50;
      @(negedge clock);
      start = 1'b1; op_in = 3'd0; op1_in = 32'h3f800000; op2_in = 32'h3f800000;
      @(negedge clock);
      start = 1'b0;
      repeat (4) @(negedge clock);
      check("rstmid_req_before", {31'd0, add_request}, 32'd1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("rstmid_req_after", {31'd0, add_request}, 32'd0);
      check("rstmid_busy_after", {31'd0, busy}, 32'd0);
      any = 1'b0;
      for (k = 0; k < 6; k++) begin
         any |= done;
         @(negedge clock);
      end
      check("rstmid_no_done", {31'd0, any}, 32'd0);
      unit_lat[0] = 3; unit_res[0] = 32'h40a00000;
      push(32'h40a00000, 1'b0);
      run_op(3'd0, 32'h40000000, 32'h40400000, n, seen, u2);
      check("rstmid_next_latency", n, 32'd5);
      wait_idle("rstmid_next_idle");

      // Watchdog abort on the 8-cycle instance: DIV that never gets ready
      begin
         exp_t e;
         e.res = 32'h7fc00000; e.to = 1'b1;
         wd_q.push_back(e);
      end
      @(negedge clock);
      wd_start = 1'b1;
      n = 0; any = 1'b0;
      do begin
         @(negedge clock);
         wd_start = 1'b0;
         n++;
         any |= wd_div_req;
      end while (!wd_done && n < 100);
      check("wd_latency", n, 32'd9);
      check("wd_req_was_high", {31'd0, any}, 32'd1);
      check("wd_req_low_at_done", {31'd0, wd_div_req}, 32'd0);
      k = 0;
      while (wd_busy && k < 20) begin
         @(negedge clock);
         k++;
      end
      check("wd_idle", {31'd0, wd_busy}, 32'd0);

      repeat (3) @(negedge clock);
      check("queue_empty", exp_q.size(), 32'd0);
      check("wd_queue_empty", wd_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
`default_nettype wire
